// File: rtl/rr_req_gnt_arbiter_if.sv
// Request/grant bundle between N requesters and the round-robin arbiter.
// The master side drives req; the slave side (arbiter) returns gnt, gnt_id and busy.
interface rr_req_gnt_arbiter_if #(
   parameter int N = 4
) ();
   logic [N-1:0]         req;
   logic [N-1:0]         gnt;
   logic [$clog2(N)-1:0] gnt_id;
   logic                 busy;

   modport master (output req, input gnt, input gnt_id, input busy);
   modport slave  (input req, output gnt, output gnt_id, output busy);
endinterface

// File: rtl/rr_req_gnt_arbiter.sv
// Round-robin req/gnt arbiter with registered grants and a hold-time preemption limit.
// Define RR_ARB_ASSERT_EN to compile in the handshake and fairness assertions.
module rr_req_gnt_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input logic                clk,
   input logic                rst,
   rr_req_gnt_arbiter_if.slave bus
);
   localparam int IW = $clog2(N);
   localparam int CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0] HOLD_LIM   = CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
   localparam bit            PREEMPT_EN = (MAX_HOLD != 0);

   typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t          state_r, state_s;
   logic [N-1:0]    gnt_r, gnt_s;
   logic [IW-1:0]   gnt_id_r, gnt_id_s;
   logic [IW-1:0]   last_r, last_s;
   logic [CW-1:0]   hold_cnt_r, hold_cnt_s;
   logic            busy_r;
   logic [IW-1:0]   winner_s;
   logic            owner_req_s;
   logic            others_s;
   logic            preempt_s;

   // First set bit scanning last+1, last+2, ... modulo N; returns last if nothing is set.
   function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] l);
      logic [IW-1:0] w;
      logic [IW-1:0] idx;
      logic          found;
      w     = l;
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
         idx   = IW'((int'(l) + k) % N);
         w     = (!found && r[idx]) ? idx : w;
         found = found | r[idx];
      end
      return w;
   endfunction

   // Arbitration decode: winner, owner status and the preemption condition.
   always_comb begin
      winner_s    = rr_pick(bus.req, last_r);
      owner_req_s = bus.req[gnt_id_r];
      others_s    = |(bus.req & ~gnt_r);
      preempt_s   = PREEMPT_EN && (hold_cnt_r == HOLD_LIM) && others_s;
   end

   // Next-state and next-output logic of the IDLE/GRANT machine.
   always_comb begin
      state_s    = state_r;
      gnt_s      = gnt_r;
      gnt_id_s   = gnt_id_r;
      last_s     = last_r;
      hold_cnt_s = hold_cnt_r;
      case (state_r)
         IDLE: begin
            if (|bus.req) begin
               state_s    = GRANT;
               gnt_s      = {{(N-1){1'b0}}, 1'b1} << winner_s;
               gnt_id_s   = winner_s;
               last_s     = winner_s;
               hold_cnt_s = {CW{1'b0}};
            end else begin
               state_s = IDLE;
            end
         end
         GRANT: begin
            // Release takes priority; a simultaneous preemption has the same outcome.
            if (!owner_req_s || preempt_s) begin
               state_s = IDLE;
               gnt_s   = {N{1'b0}};
            end else begin
               state_s    = GRANT;
               hold_cnt_s = (hold_cnt_r == HOLD_LIM) ? hold_cnt_r : hold_cnt_r + CW'(1);
            end
         end
         default: begin
            state_s = IDLE;
            gnt_s   = {N{1'b0}};
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         gnt_r      <= {N{1'b0}};
         gnt_id_r   <= {IW{1'b0}};
         last_r     <= IW'(N - 1);
         hold_cnt_r <= {CW{1'b0}};
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         gnt_r      <= gnt_s;
         gnt_id_r   <= gnt_id_s;
         last_r     <= last_s;
         hold_cnt_r <= hold_cnt_s;
         busy_r     <= |gnt_s;
      end
   end

   assign bus.gnt    = gnt_r;
   assign bus.gnt_id = gnt_id_r;
   assign bus.busy   = busy_r;

`ifdef RR_ARB_ASSERT_EN
   rr_req_gnt_arbiter_sva #(.N(N), .MAX_HOLD(MAX_HOLD)) u_sva (
      .clk  (clk),
      .rst  (rst),
      .req  (bus.req),
      .gnt  (gnt_r),
      .busy (busy_r)
   );
`endif
endmodule

`ifdef RR_ARB_ASSERT_EN
// Handshake, exclusivity, hold-limit and fairness checks for the arbiter.
module rr_req_gnt_arbiter_sva #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input logic         clk,
   input logic         rst,
   input logic [N-1:0] req,
   input logic [N-1:0] gnt,
   input logic         busy
);
   localparam int BOUND = (N - 1) * (MAX_HOLD + 1) + 1;

   a_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
   a_busy:    assert property (@(posedge clk) disable iff (rst) busy == |gnt);

   for (genvar i = 0; i < N; i++) begin : g_req
      a_gnt_req: assert property (@(posedge clk) disable iff (rst) gnt[i] |-> $past(req[i]));
      if (MAX_HOLD != 0) begin : g_lim
         // A continuously held request must see its grant within BOUND cycles.
         a_fair: assert property (@(posedge clk) disable iff (rst)
            not ($rose(req[i]) ##1 (req[i] && !gnt[i]) [*(BOUND + 1)]));
         a_hold: assert property (@(posedge clk) disable iff (rst)
            not ((gnt[i] && |(req & ~gnt)) [*(MAX_HOLD + 1)]));
      end
   end
endmodule
`endif

// File: doc/rr_req_gnt_arbiter.md
# rr_req_gnt_arbiter

Round-robin arbiter that shares one resource among `N` requesters over a per-requester `req`/`gnt` handshake. It is clocked on `posedge clk` and issues a registered grant one cycle after it samples a request, which is the `req |=> gnt` contract. A hold counter with a preemption limit bounds how long any one requester can keep the grant. Optional embedded SVA checks the handshake and the fairness bound.

## Interface
Parameters:
- `N`, 4, number of requesters; minimum 2.
- `MAX_HOLD`, 8, maximum cycles one grant may last while other requests are pending. 0 means no limit.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req`  in  N  request vector; bit i is requester i.
- `gnt`  out  N  one-hot-or-zero grant vector, registered.
- `gnt_id`  out  $clog2(N)  index of the current owner; valid only when `busy` is 1.
- `busy`  out  1  1 while any grant is active; equals `|gnt`.

## Operation
- State machine with two states:
  - IDLE: no grant active.
  - GRANT: one owner holds `gnt`.
- Registers:
  - `last` is the most recent winner.
  - `hold_cnt` has width $clog2(MAX_HOLD+1), with a minimum of 1.
- IDLE, `req` == 0: stay in IDLE.
- IDLE, `req` != 0:
  - Winner is the first set bit scanning `last+1, last+2, …` modulo N.
  - `gnt` <= onehot(winner), `gnt_id` <= winner, `last` <= winner, `hold_cnt` <= 0, next state GRANT.
- GRANT, owner's `req` deasserted: `gnt` <= 0, next state IDLE. This is a voluntary release.
- GRANT, `MAX_HOLD` != 0, `hold_cnt` == MAX_HOLD-1, and any other `req` bit set: `gnt` <= 0, next state IDLE. This is a preemption.
- GRANT, otherwise: keep `gnt`; `hold_cnt` increments and saturates at MAX_HOLD-1.
- A requester that is not the owner may raise or drop `req` freely. Only the owner's `req` affects the GRANT state.
- `gnt_id` holds its last value while in IDLE.

## Timing
- Reset values: `gnt` = 0, `gnt_id` = 0, `busy` = 0, state = IDLE, `last` = N-1 (so requester 0 wins first), `hold_cnt` = 0.
- Grant latency: `req` sampled high at edge E in IDLE gives `gnt` high after E.
- Release latency:
  - Owner `req` sampled low at edge E gives `gnt` low after E.
  - The next grant goes out no earlier than edge E+1. There is always at least one IDLE cycle between two grants.
- Preemption: the owner holds `gnt` for exactly MAX_HOLD cycles. After the IDLE cycle, the next requester in round-robin order wins, because `last` now points at the preempted owner.
- Fairness bound: a requester holding `req` continuously is granted within (N-1)·(MAX_HOLD+1)+1 cycles. This applies only when `MAX_HOLD` != 0.
- Simultaneous release and preemption on the same edge: handled as a release; the outcome is identical.
- Owner drops `req` on the same edge the counter saturates: handled as a release.
- `rst` high at any edge, including mid-grant: all registers take their reset values after that edge, and `gnt` is 0 the following cycle.
- There are no combinational paths from `req` to `gnt`.

## Configuration
- Macro `RR_ARB_ASSERT_EN`.
- When defined, concurrent assertions are compiled in. All are clocked `@(posedge clk)` and carry `disable iff (rst)`:
  - `$onehot0(gnt)`.
  - `busy == |gnt`.
  - For each i: `gnt[i] |-> $past(req[i])`.
  - For each i: `$rose(req[i]) |=> ##[0:BOUND] gnt[i]`, where BOUND is the fairness bound from Timing. Only present when `MAX_HOLD` != 0, and only required when `req[i]` is held until granted.
  - When `MAX_HOLD` != 0: no `gnt` bit stays high more than MAX_HOLD consecutive cycles while another `req` bit is set.
- When not defined, no assertion code is present. Functional behaviour is identical either way.

## Test plan
- Reset then single request: `rst` for 2 cycles, then `req`=4'b0100 held → `gnt`=4'b0100 one cycle later, `gnt_id`=2, `busy`=1; drop `req` → `gnt`=0 one cycle later.
- Round-robin order: `req`=4'b1111 held with each owner releasing after 3 cycles → grants in order 0,1,2,3,0, separated by one IDLE cycle.
- Preemption with MAX_HOLD=8: `req`=4'b0011 held continuously → `gnt`=0001 for exactly 8 cycles, 1 IDLE cycle, then `gnt`=0010 for 8 cycles, repeating.
- No preemption when alone: `req`=4'b0001 held for 30 cycles → `gnt`=0001 continuously for 30 cycles; `hold_cnt` saturates without release.
- Reset mid-grant: `gnt`=0100 active, `rst` pulsed 1 cycle → `gnt`=0 after that edge. With `req`=4'b1100 held afterwards, the next grant goes to requester 2 (`last` was reset to 3).
- With `RR_ARB_ASSERT_EN` defined: random `req` for 10k cycles with MAX_HOLD=4 → zero assertion failures. Forcing `gnt` to 0011 via `force` → the onehot0 assertion fires.
